ula_8_bits_reg: RTL and testbench

- 8-bit arithmetic/logic unit built from two cascaded 4-bit slices with a ripple carry between them.
- Provides 16 arithmetic functions (m=0) and 16 logic functions (m=1), selected by s.
- Flags: carry-out, signed overflow and A=B compare.
- All outputs are registered on one clock; the block sits in the datapath between the operand registers and the writeback/flag logic.

---
 rtl/ula_pkg.sv | 39 +++
 rtl/ula_4_bits_slice.sv | 33 +++
 rtl/ula_8_bits_reg.sv | 162 ++++++++++++++++
 tb/tb_ula_8_bits_reg.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ---------------------------------------------------------------------------
// ula_pkg
// Shared constants and types for the registered ALU (ula_8_bits_reg) and its
// 4-bit adder slice (ula_4_bits_slice).
//   ULA_WIDTH   : default operand/result width
//   SLICE_WIDTH : width of one ripple-carry adder slice
//   mode_e      : m input encoding (ARITH / LOGIC)
//   FN_*        : names of the 16 s codes (arithmetic meaning with m=0)
// ---------------------------------------------------------------------------
package ula_pkg;

   localparam int ULA_WIDTH   = 8;
   localparam int SLICE_WIDTH = 4;

   typedef enum logic {
      ARITH = 1'b0,
      LOGIC = 1'b1
   } mode_e;

   // Arithmetic-mode function codes; with m=1 the same codes pick the
   // bitwise functions listed in the top-level logic mux.
   localparam logic [3:0] FN_PASS_A    = 4'b0000;  // A + cin
   localparam logic [3:0] FN_DEC_A     = 4'b0001;  // A - 1 + cin
   localparam logic [3:0] FN_OR_AB     = 4'b0010;  // (A|B) + cin
   localparam logic [3:0] FN_AND_AB    = 4'b0011;  // (A&B) + cin
   localparam logic [3:0] FN_DBL_A     = 4'b0100;  // A + A + cin
   localparam logic [3:0] FN_ADD       = 4'b0101;  // A + B + cin
   localparam logic [3:0] FN_A_PLS_AND = 4'b0110;  // A + (A&B) + cin
   localparam logic [3:0] FN_A_PLS_OR  = 4'b0111;  // A + (A|B) + cin
   localparam logic [3:0] FN_SUB       = 4'b1000;  // A - B - cin
   localparam logic [3:0] FN_RSUB      = 4'b1001;  // B - A - cin
   localparam logic [3:0] FN_NEG_A     = 4'b1010;  // -A - cin
   localparam logic [3:0] FN_PASS_B    = 4'b1011;  // B + cin
   localparam logic [3:0] FN_DEC_B     = 4'b1100;  // B - 1 + cin
   localparam logic [3:0] FN_DBL_B     = 4'b1101;  // B + B + cin
   localparam logic [3:0] FN_XOR_AB    = 4'b1110;  // (A^B) + cin
   localparam logic [3:0] FN_CONST_CIN = 4'b1111;  // 0 + cin

endpackage

// File: rtl/ula_4_bits_slice.sv
// ---------------------------------------------------------------------------
// ula_4_bits_slice
// One 4-bit ripple adder slice: {o_c, o_sum} = i_x + i_y + i_c.
// Also exports the MSB of each operand so the top can form signed overflow
// from the most significant slice.
//   i_x, i_y  : operand nibbles
//   i_c       : carry in (from the previous slice or the ALU carry-in)
//   o_sum     : sum nibble
//   o_c       : carry out of the nibble
//   o_x_msb   : i_x[3]
//   o_y_msb   : i_y[3]
// ---------------------------------------------------------------------------
module ula_4_bits_slice
   import ula_pkg::*;
(
   input  logic [SLICE_WIDTH-1:0] i_x,
   input  logic [SLICE_WIDTH-1:0] i_y,
   input  logic                   i_c,
   output logic [SLICE_WIDTH-1:0] o_sum,
   output logic                   o_c,
   output logic                   o_x_msb,
   output logic                   o_y_msb
);

   logic [SLICE_WIDTH:0] w_total;

   assign w_total = {1'b0, i_x} + {1'b0, i_y} + {{SLICE_WIDTH{1'b0}}, i_c};
   assign o_sum   = w_total[SLICE_WIDTH-1:0];
   assign o_c     = w_total[SLICE_WIDTH];
   assign o_x_msb = i_x[SLICE_WIDTH-1];
   assign o_y_msb = i_y[SLICE_WIDTH-1];

endmodule

// File: rtl/ula_8_bits_reg.sv
// ---------------------------------------------------------------------------
// ula_8_bits_reg
// Registered ALU: 16 arithmetic functions (m=0) built on a chain of 4-bit
// ripple slices, 16 bitwise functions (m=1), plus carry, signed overflow and
// A==B flags. All outputs are registered with one cycle of latency; reset is
// asynchronous and active-high.
//   clk, rst  : clock, async active-high reset
//   a, b      : operands (WIDTH bits)
//   s, m      : function select and mode (0 arith, 1 logic)
//   c_in      : carry-in (borrow-in for subtract codes)
//   f         : registered result
//   a_eq_b    : registered a==b
//   c_out     : registered carry out of the MSB (0 in logic mode)
//   overflow  : registered two's-complement overflow (0 in logic mode)
// Build option ULA_ZERO_FLAG_EN adds output zero: registered (f_next == 0).
// ---------------------------------------------------------------------------
module ula_8_bits_reg
   import ula_pkg::*;
#(
   parameter int WIDTH = ULA_WIDTH
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             c_in,
   output logic [WIDTH-1:0] f,
   output logic             a_eq_b,
   output logic             c_out,
   output logic             overflow
`ifdef ULA_ZERO_FLAG_EN
   ,
   output logic             zero
`endif
);

   localparam int N_SLICES = WIDTH / SLICE_WIDTH;
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

   mode_e            w_mode;
   logic [WIDTH-1:0] w_x;
   logic [WIDTH-1:0] w_y;
   logic             w_k;
   logic [WIDTH-1:0] w_sum;
   logic [N_SLICES:0] w_carry;
   logic [N_SLICES-1:0] w_x_msb;
   logic [N_SLICES-1:0] w_y_msb;
   logic             w_unused_msbs;
   logic             w_ovf_arith;
   logic [WIDTH-1:0] w_logic;
   logic [WIDTH-1:0] w_f_next;
   logic             w_c_next;
   logic             w_ov_next;

   assign w_mode = mode_e'(m);

   // Operand steering: every arithmetic code reduces to X + Y + k.
   // Subtract codes use ~operand with an inverted carry so c_in acts as a
   // borrow and c_out=1 means "no borrow".
   always_comb begin
      w_x = '0;
      w_y = '0;
      w_k = c_in;
      case (s)
         FN_PASS_A:    begin w_x = a;     w_y = '0;       end
         FN_DEC_A:     begin w_x = a;     w_y = ALL_ONES; end
         FN_OR_AB:     begin w_x = a | b; w_y = '0;       end
         FN_AND_AB:    begin w_x = a & b; w_y = '0;       end
         FN_DBL_A:     begin w_x = a;     w_y = a;        end
         FN_ADD:       begin w_x = a;     w_y = b;        end
         FN_A_PLS_AND: begin w_x = a;     w_y = a & b;    end
         FN_A_PLS_OR:  begin w_x = a;     w_y = a | b;    end
         FN_SUB:       begin w_x = a;     w_y = ~b; w_k = ~c_in; end
         FN_RSUB:      begin w_x = b;     w_y = ~a; w_k = ~c_in; end
         FN_NEG_A:     begin w_x = '0;    w_y = ~a; w_k = ~c_in; end
         FN_PASS_B:    begin w_x = b;     w_y = '0;       end
         FN_DEC_B:     begin w_x = b;     w_y = ALL_ONES; end
         FN_DBL_B:     begin w_x = b;     w_y = b;        end
         FN_XOR_AB:    begin w_x = a ^ b; w_y = '0;       end
         default:      begin w_x = '0;    w_y = '0;       end
      endcase
   end

   // Ripple chain: each slice's carry-out feeds the next slice's carry-in.
   assign w_carry[0] = w_k;

   genvar gi;
   generate
      for (gi = 0; gi < N_SLICES; gi++) begin : g_slice
         ula_4_bits_slice u_slice (
            .i_x     (w_x[gi*SLICE_WIDTH +: SLICE_WIDTH]),
            .i_y     (w_y[gi*SLICE_WIDTH +: SLICE_WIDTH]),
            .i_c     (w_carry[gi]),
            .o_sum   (w_sum[gi*SLICE_WIDTH +: SLICE_WIDTH]),
            .o_c     (w_carry[gi+1]),
            .o_x_msb (w_x_msb[gi]),
            .o_y_msb (w_y_msb[gi])
         );
      end
   endgenerate

   // Only the top slice's operand MSBs matter for overflow; the lower ones
   // are folded here so they are not left dangling.
   assign w_unused_msbs = ^{w_x_msb, w_y_msb};

   assign w_ovf_arith = (w_x_msb[N_SLICES-1] == w_y_msb[N_SLICES-1]) &&
                        (w_sum[WIDTH-1] != w_x_msb[N_SLICES-1]);

   always_comb begin
      w_logic = '0;
      case (s)
         4'b0000: w_logic = ~a;
         4'b0001: w_logic = ~(a | b);
         4'b0010: w_logic = ~a & b;
         4'b0011: w_logic = '0;
         4'b0100: w_logic = ~(a & b);
         4'b0101: w_logic = ~b;
         4'b0110: w_logic = a ^ b;
         4'b0111: w_logic = a & ~b;
         4'b1000: w_logic = ~a | b;
         4'b1001: w_logic = ~(a ^ b);
         4'b1010: w_logic = b;
         4'b1011: w_logic = a & b;
         4'b1100: w_logic = ALL_ONES;
         4'b1101: w_logic = a | ~b;
         4'b1110: w_logic = a | b;
         4'b1111: w_logic = a;
         default: w_logic = '0;
      endcase
   end

   assign w_f_next  = (w_mode == LOGIC) ? w_logic : w_sum;
   assign w_c_next  = (w_mode == LOGIC) ? 1'b0 : w_carry[N_SLICES];
   assign w_ov_next = (w_mode == LOGIC) ? 1'b0 : w_ovf_arith;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f        <= '0;
         a_eq_b   <= 1'b0;
         c_out    <= 1'b0;
         overflow <= 1'b0;
      end else begin
         f        <= w_f_next;
         a_eq_b   <= (a == b);
         c_out    <= w_c_next;
         overflow <= w_ov_next;
      end
   end

`ifdef ULA_ZERO_FLAG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         zero <= 1'b0;
      end else begin
         zero <= (w_f_next == '0);
      end
   end
`endif

endmodule

// File: tb/tb_ula_8_bits_reg.sv
// ---------------------------------------------------------------------------
// tb_ula_8_bits_reg
// Directed and random checks of ula_8_bits_reg against an integer-arithmetic
// reference model. Optional zero flag checked when ULA_ZERO_FLAG_EN is set.
// ---------------------------------------------------------------------------
module tb_ula_8_bits_reg;

   logic       clk;
   logic       rst;
   logic [7:0] a;
   logic [7:0] b;
   logic [3:0] s;
   logic       m;
   logic       c_in;
   logic [7:0] f;
   logic       a_eq_b;
   logic       c_out;
   logic       overflow;
`ifdef ULA_ZERO_FLAG_EN
   logic       zero;
`endif

   int n_cmp = 0;
   int n_mis = 0;

   ula_8_bits_reg #(.WIDTH(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .a        (a),
      .b        (b),
      .s        (s),
      .m        (m),
      .c_in     (c_in),
      .f        (f),
      .a_eq_b   (a_eq_b),
      .c_out    (c_out),
      .overflow (overflow)
`ifdef ULA_ZERO_FLAG_EN
      ,
      .zero     (zero)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Reference model: plain integer arithmetic on 0..255 values.
   function automatic void ref_model(input int ia, input int ib, input int is, input int im,
                                     input int icin, output int rf, output int rc, output int rov);
      int x, y, k, sum, sx, sy, ss;
      int na, nb;
      na = 255 - ia;
      nb = 255 - ib;
      rf = 0; rc = 0; rov = 0;
      if (im == 0) begin
         k = icin;
         x = 0; y = 0;
         case (is)
            0:  begin x = ia;      y = 0;   end
            1:  begin x = ia;      y = 255; end
            2:  begin x = ia | ib; y = 0;   end
            3:  begin x = ia & ib; y = 0;   end
            4:  begin x = ia;      y = ia;  end
            5:  begin x = ia;      y = ib;  end
            6:  begin x = ia;      y = ia & ib; end
            7:  begin x = ia;      y = ia | ib; end
            8:  begin x = ia;      y = nb;  k = 1 - icin; end
            9:  begin x = ib;      y = na;  k = 1 - icin; end
            10: begin x = 0;       y = na;  k = 1 - icin; end
            11: begin x = ib;      y = 0;   end
            12: begin x = ib;      y = 255; end
            13: begin x = ib;      y = ib;  end
            14: begin x = ia ^ ib; y = 0;   end
            default: begin x = 0;  y = 0;   end
         endcase
         sum = x + y + k;
         rf  = sum % 256;
         rc  = sum / 256;
         // Signed overflow: the true signed sum leaves the 8-bit range.
         sx  = (x >= 128) ? x - 256 : x;
         sy  = (y >= 128) ? y - 256 : y;
         ss  = sx + sy + k;
         rov = (ss > 127 || ss < -128) ? 1 : 0;
      end else begin
         case (is)
            0:  rf = na;
            1:  rf = 255 - (ia | ib);
            2:  rf = na & ib;
            3:  rf = 0;
            4:  rf = 255 - (ia & ib);
            5:  rf = nb;
            6:  rf = ia ^ ib;
            7:  rf = ia & nb;
            8:  rf = na | ib;
            9:  rf = 255 - (ia ^ ib);
            10: rf = ib;
            11: rf = ia & ib;
            12: rf = 255;
            13: rf = ia | nb;
            14: rf = ia | ib;
            default: rf = ia;
         endcase
      end
   endfunction

   task automatic check_outputs(input string tag, input int ia, input int ib, input int is,
                                input int im, input int icin);
      int ef, ec, eov;
      ref_model(ia, ib, is, im, icin, ef, ec, eov);
      $display("op %s a=%02h b=%02h s=%0h m=%0d cin=%0d -> f=%02h c=%0d ov=%0d eq=%0d (model f=%02h c=%0d ov=%0d)",
               tag, ia, ib, is, im, icin, f, c_out, overflow, a_eq_b, ef, ec, eov);
      chk({tag, ".f"},  32'(f),        32'(ef));
      chk({tag, ".c"},  32'(c_out),    32'(ec));
      chk({tag, ".ov"}, 32'(overflow), 32'(eov));
      chk({tag, ".eq"}, 32'(a_eq_b),   32'((ia == ib) ? 1 : 0));
`ifdef ULA_ZERO_FLAG_EN
      chk({tag, ".zero"}, 32'(zero), 32'((ef == 0) ? 1 : 0));
`endif
   endtask

   task automatic do_op(input string tag, input int ia, input int ib, input int is,
                        input int im, input int icin);
      @(negedge clk);
      a = 8'(ia); b = 8'(ib); s = 4'(is); m = 1'(im); c_in = 1'(icin);
      @(posedge clk);
      #1;
      check_outputs(tag, ia, ib, is, im, icin);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".f"},  32'(f),        32'h0);
      chk({tag, ".c"},  32'(c_out),    32'h0);
      chk({tag, ".ov"}, 32'(overflow), 32'h0);
      chk({tag, ".eq"}, 32'(a_eq_b),   32'h0);
`ifdef ULA_ZERO_FLAG_EN
      chk({tag, ".zero"}, 32'(zero),   32'h0);
`endif
   endtask

   initial begin
      rst = 1'b1;
      a = 8'h00; b = 8'h00; s = 4'h0; m = 1'b0; c_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      $display("reset state check");
      chk_all_zero("reset");

      @(negedge clk);
      rst = 1'b0;

      // Directed vectors
      do_op("add_1_2",    8'h01, 8'h02, 5, 0, 0);
      do_op("add_slice",  8'h0F, 8'h01, 5, 0, 0);
      do_op("add_ovf",    8'h7F, 8'h01, 5, 0, 0);
      do_op("add_carry",  8'hFF, 8'h01, 5, 0, 0);
      do_op("sub_pos",    8'h0A, 8'h05, 8, 0, 0);
      do_op("sub_neg",    8'h05, 8'h0A, 8, 0, 0);
      do_op("sub_ovf",    8'h80, 8'h01, 8, 0, 0);
      do_op("sub_borrow", 8'h0A, 8'h05, 8, 0, 1);
      do_op("add_cin",    8'h0F, 8'h00, 5, 0, 1);
      do_op("rsub",       8'h03, 8'h10, 9, 0, 0);
      do_op("neg",        8'h01, 8'h00, 10, 0, 0);
      do_op("dec_a",      8'h00, 8'h00, 1, 0, 0);
      do_op("eq_55",      8'h55, 8'h55, 3, 1, 0);
      do_op("ne_54",      8'h55, 8'h54, 3, 1, 0);
      do_op("ne_d5",      8'h55, 8'hD5, 5, 0, 1);
      do_op("log_xor",    8'hF0, 8'h3C, 6, 1, 1);
      do_op("log_and",    8'hF0, 8'h3C, 11, 1, 0);
      do_op("log_or",     8'hF0, 8'h3C, 14, 1, 1);

      // Sweep every code in both modes with one fixed operand pair
      for (int is = 0; is < 16; is++) begin
         do_op("sweep_arith", 8'hA7, 8'h5C, is, 0, is % 2);
         do_op("sweep_logic", 8'hA7, 8'h5C, is, 1, is % 2);
      end

      // Asynchronous reset in the middle of a stream
      do_op("pre_rst", 8'h12, 8'h34, 5, 0, 0);
      @(negedge clk);
      a = 8'h40; b = 8'h40; s = 4'h5; m = 1'b0; c_in = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      $display("async reset asserted between edges");
      chk_all_zero("rst_async");
      @(posedge clk);
      #1;
      chk_all_zero("rst_held");
      @(negedge clk);
      rst = 1'b0;
      a = 8'h0F; b = 8'h01; s = 4'h5; m = 1'b0; c_in = 1'b0;
      #1;
      chk_all_zero("rst_release_no_edge");
      @(posedge clk);
      #1;
      check_outputs("first_after_rst", 8'h0F, 8'h01, 5, 0, 0);

`ifdef ULA_ZERO_FLAG_EN
      do_op("zero_ff_01", 8'hFF, 8'h01, 5, 0, 0);
      chk("zero_ff_01.flag", 32'(zero), 32'h1);
`endif

      // Randomized stimulus
      for (int i = 0; i < 200; i++) begin
         int ra, rb;
         ra = int'($urandom_range(0, 255));
         rb = (($urandom_range(0, 7)) == 0) ? ra : int'($urandom_range(0, 255));
         do_op("rand", ra, rb, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
